// File: rtl/bus_mux_reg.sv
// N-channel registered bus multiplexer with valid/stall capture and round-robin scan.
// Define BUS_MUX_REG_SELERR_EN to flag direct-mode selects at or beyond CHANNELS.
module bus_mux_reg #(
    parameter int  WIDTH    = 16,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [CHANNELS*WIDTH-1:0] Data,
    input  logic [SEL_W-1:0]          Sel,
    input  logic                      Mode,
    input  logic                      Load,
    input  logic                      Stall,
    output logic [WIDTH-1:0]          Q,
    output logic                      QValid,
    output logic [SEL_W-1:0]          QChan,
    output logic                      SelErr
);

    localparam int SLOTS = 1 << SEL_W;

    logic [WIDTH-1:0] chan_data [SLOTS];
    logic [SEL_W-1:0] sel_map   [SLOTS];

    // Select codes past the last channel alias onto channel 0, so the
    // non-detecting build needs no comparator to land on Data[0]/QChan=0.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < CHANNELS) begin : g_live
                assign chan_data[gi] = Data[gi*WIDTH +: WIDTH];
                assign sel_map[gi]   = SEL_W'(gi);
            end else begin : g_alias
                assign chan_data[gi] = Data[WIDTH-1:0];
                assign sel_map[gi]   = '0;
            end
        end
    endgenerate

    logic [WIDTH-1:0] q_reg;
    logic             q_valid_reg;
    logic [SEL_W-1:0] q_chan_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] cap_idx;
    logic [WIDTH-1:0] cap_data;
    logic             sel_bad;

    always_comb begin
        cap_idx  = Mode ? ptr_reg : sel_map[Sel];
        cap_data = chan_data[cap_idx];
        ptr_next = (ptr_reg == SEL_W'(CHANNELS - 1)) ? '0 : ptr_reg + SEL_W'(1);
    end

`ifdef BUS_MUX_REG_SELERR_EN
    logic sel_err_reg;

    generate
        if (CHANNELS == SLOTS) begin : g_full
            assign sel_bad = 1'b0;
        end else begin : g_partial
            assign sel_bad = ~Mode & (Sel >= SEL_W'(CHANNELS));
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sel_err_reg <= 1'b0;
        end else begin
            sel_err_reg <= ~Stall & Load & sel_bad;
        end
    end

    assign SelErr = sel_err_reg;
`else
    assign sel_bad = 1'b0;
    assign SelErr  = 1'b0;
`endif

    // Stall freezes everything; a rejected select holds Q/QChan but drops QValid.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
            q_chan_reg  <= '0;
            ptr_reg     <= '0;
        end else if (!Stall) begin
            q_valid_reg <= 1'b0;
            if (Load && !sel_bad) begin
                q_reg       <= cap_data;
                q_chan_reg  <= cap_idx;
                q_valid_reg <= 1'b1;
                if (Mode) begin
                    ptr_reg <= ptr_next;
                end
            end
        end
    end

    assign Q      = q_reg;
    assign QValid = q_valid_reg;
    assign QChan  = q_chan_reg;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Randomized and directed check of bus_mux_reg (3- and 4-channel builds)
// against a rule-level reference model.
module tb_bus_mux_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] data3;
    logic [63:0] data4;
    logic [1:0]  sel   [2];
    logic        mode  [2];
    logic        load  [2];
    logic        stall [2];

    logic [15:0] q3, q4;
    logic        v3, v4, e3, e4;
    logic [1:0]  c3, c4;

    logic [15:0] dv [2][4];
    int          nch [2] = '{3, 4};

    logic [15:0] m_q    [2];
    logic        m_v    [2];
    logic        m_err  [2];
    int          m_chan [2];
    int          m_ptr  [2];

    int vectors    = 0;
    int miscompares = 0;
    int tick_no    = 0;

    always #5 clk = ~clk;

    bus_mux_reg #(.WIDTH(16), .CHANNELS(3)) dut3 (
        .Clock(clk), .Reset(rst), .Data(data3), .Sel(sel[0]), .Mode(mode[0]),
        .Load(load[0]), .Stall(stall[0]), .Q(q3), .QValid(v3), .QChan(c3), .SelErr(e3)
    );

    bus_mux_reg #(.WIDTH(16), .CHANNELS(4)) dut4 (
        .Clock(clk), .Reset(rst), .Data(data4), .Sel(sel[1]), .Mode(mode[1]),
        .Load(load[1]), .Stall(stall[1]), .Q(q4), .QValid(v4), .QChan(c4), .SelErr(e4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, obs, exp, tick_no);
        end
    endtask

    task automatic set_data();
        data3 = {dv[0][2], dv[0][1], dv[0][0]};
        data4 = {dv[1][3], dv[1][2], dv[1][1], dv[1][0]};
    endtask

    // Reference: what the rules say one rising edge does to the visible state.
    task automatic model_step(input int i);
        int s;
        s = int'(sel[i]);
        if (rst) begin
            m_q[i] = '0; m_v[i] = 1'b0; m_chan[i] = 0; m_err[i] = 1'b0; m_ptr[i] = 0;
        end else if (stall[i]) begin
            m_err[i] = 1'b0;
        end else begin
            m_v[i]   = 1'b0;
            m_err[i] = 1'b0;
            if (load[i]) begin
                if (mode[i]) begin
                    m_q[i] = dv[i][m_ptr[i]]; m_chan[i] = m_ptr[i]; m_v[i] = 1'b1;
                    m_ptr[i] = (m_ptr[i] + 1) % nch[i];
                end else if (s < nch[i]) begin
                    m_q[i] = dv[i][s]; m_chan[i] = s; m_v[i] = 1'b1;
                end else begin
`ifdef BUS_MUX_REG_SELERR_EN
                    m_err[i] = 1'b1;
`else
                    m_q[i] = dv[i][0]; m_chan[i] = 0; m_v[i] = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        tick_no++;
        check("q3", q3, m_q[0]);   check("v3", v3, m_v[0]);
        check("c3", c3, m_chan[0]); check("e3", e3, m_err[0]);
        check("q4", q4, m_q[1]);   check("v4", v4, m_v[1]);
        check("c4", c4, m_chan[1]); check("e4", e4, m_err[1]);
        $display("tick %0d rst=%0b | ch3 q=%h v=%0b c=%0d e=%0b | ch4 q=%h v=%0b c=%0d e=%0b",
                 tick_no, rst, q3, v3, c3, e3, q4, v4, c4, e4);
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            sel[i] = '0; mode[i] = 1'b0; load[i] = 1'b0; stall[i] = 1'b0;
        end
    endtask

    initial begin
        int rr_exp [5] = '{0, 1, 2, 0, 1};
        idle();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 'x; m_v[i] = 'x; m_chan[i] = 0; m_err[i] = 'x; m_ptr[i] = 0;
            for (int k = 0; k < 4; k++) dv[i][k] = 16'hFFFF;
            load[i] = 1'b1;
        end
        set_data();

        // Reset dominates Load with all-ones data.
        repeat (2) begin
            tick();
            check("rst_q", q4, 16'h0); check("rst_v", v4, 1'b0);
            check("rst_c", c4, 2'd0);  check("rst_e", e3, 1'b0);
        end
        rst = 1'b0;
        idle();

        // Direct select on the 4-channel build.
        dv[1][0] = 16'h1111; dv[1][1] = 16'h2222; dv[1][2] = 16'h3333; dv[1][3] = 16'h4444;
        set_data();
        load[1] = 1'b1; sel[1] = 2'd2;
        tick(); check("dir_q2", q4, 16'h3333); check("dir_c2", c4, 2'd2); check("dir_v2", v4, 1'b1);
        sel[1] = 2'd0;
        tick(); check("dir_q0", q4, 16'h1111); check("dir_c0", c4, 2'd0); check("dir_v0", v4, 1'b1);
        load[1] = 1'b0; sel[1] = 2'd3;
        tick(); check("dir_vdrop", v4, 1'b0); check("dir_qhold", q4, 16'h1111);

        // Round-robin wrap on the 3-channel build.
        dv[0][0] = 16'hA0A0; dv[0][1] = 16'hB1B1; dv[0][2] = 16'hC2C2;
        set_data();
        mode[0] = 1'b1; load[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_chan", c3, rr_exp[k]);
            check("rr_q", q3, dv[0][rr_exp[k]]);
        end
        idle();

        // Stall holds a captured value; the pending Sel=3 load lands afterwards.
        load[1] = 1'b1; sel[1] = 2'd1;
        tick();
        stall[1] = 1'b1; sel[1] = 2'd3;
        repeat (3) begin
            tick();
            check("stall_q", q4, 16'h2222); check("stall_c", c4, 2'd1); check("stall_v", v4, 1'b1);
        end
        stall[1] = 1'b0;
        tick(); check("unstall_q", q4, 16'h4444); check("unstall_c", c4, 2'd3);
        idle();

        // Out-of-range direct select on the 3-channel build (channel 1 captured first).
        load[0] = 1'b1; sel[0] = 2'd1;
        tick();
        sel[0] = 2'd3;
        tick();
`ifdef BUS_MUX_REG_SELERR_EN
        check("oor_err", e3, 1'b1); check("oor_v", v3, 1'b0); check("oor_qhold", q3, 16'hB1B1);
        load[0] = 1'b0;
        tick(); check("oor_errpulse", e3, 1'b0);
`else
        check("oor_q", q3, 16'hA0A0); check("oor_c", c3, 2'd0); check("oor_err", e3, 1'b0);
        check("oor_v", v3, 1'b1);
`endif
        idle();

        // Mode interleave: direct loads do not disturb the scan pointer.
        rst = 1'b1; tick(); rst = 1'b0;
        load[0] = 1'b1; mode[0] = 1'b1;
        tick(); check("mix_c0", c3, 2'd0);
        mode[0] = 1'b0; sel[0] = 2'd2;
        tick(); check("mix_c2", c3, 2'd2);
        mode[0] = 1'b1;
        tick(); check("mix_c1", c3, 2'd1); check("mix_q1", q3, 16'hB1B1);
        idle();

        // Randomized traffic on both builds.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 2; i++) begin
                sel[i]   = 2'($urandom_range(0, 3));
                mode[i]  = 1'($urandom_range(0, 1));
                load[i]  = ($urandom_range(0, 9) < 7);
                stall[i] = ($urandom_range(0, 9) < 2);
                for (int k = 0; k < 4; k++) dv[i][k] = 16'($urandom);
            end
            set_data();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
